// File: rtl/alu_result_stage.sv
// Registered write-back stage behind the 32-bit ALU: buffers results and drains them as a
// valid/ready beat stream, splitting multiplies into low/high beats. Option: ALU_RESULT_PARITY_EN.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sel,
  input  logic [WIDTH-1:0] in_acc,
  input  logic [WIDTH-1:0] in_mulh,
  input  logic [7:0]       in_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       out_flag,
  output logic             out_hi,
  output logic             out_last,
  output logic [7:0]       sticky_flag,
  input  logic             sticky_clr,
`ifdef ALU_RESULT_PARITY_EN
  output logic             out_par,
  output logic [7:0]       par_err_cnt,
`endif
  output logic [CNT_W-1:0] result_cnt
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic [3:0] SEL_MUL = 4'b1110;

  typedef enum logic {ST_LO, ST_HI} state_e;

  typedef struct packed {
    logic [3:0]       sel;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mulh;
    logic [7:0]       flag;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  state_e           state_q, state_d;
  logic [7:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q;

  entry_t head;
  logic   empty, full, push, beat, pop, head_mul;

  assign empty    = (occ_q == '0);
  assign full     = (occ_q == FULL_OCC);
  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign head     = mem_q[rd_ptr_q];
  assign head_mul = (head.sel == SEL_MUL);
  assign beat     = ~empty & out_ready;
  assign pop      = beat & ((state_q == ST_HI) | ~head_mul);

  // NOTE: every output written below gets a default first, so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_data  = '0;
    out_flag  = '0;
    out_hi    = 1'b0;
    out_last  = 1'b0;
    if (!empty) begin
      out_valid = 1'b1;
      out_flag  = head.flag;
      out_hi    = (state_q == ST_HI);
      out_data  = (state_q == ST_HI) ? head.mulh : head.acc;
      out_last  = (state_q == ST_HI) | ~head_mul;
    end
    if (beat) begin
      if (state_q == ST_LO && head_mul) state_d = ST_HI;
      else                              state_d = ST_LO;
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;
    sticky_d = (sticky_clr ? 8'h00 : sticky_q) | (push ? in_flag : 8'h00);
  end

  // NOTE: storage has no reset; every payload output is gated by occupancy, so stale
  // contents can never reach the consumer.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{sel: in_sel, acc: in_acc, mulh: in_mulh, flag: in_flag};
  end

  // NOTE: state registers use non-blocking assignments so all of them update from
  // the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      state_q  <= ST_LO;
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= PTR_W'((32'(wr_ptr_q) + 1) % DEPTH);
      if (pop) begin
        rd_ptr_q <= PTR_W'((32'(rd_ptr_q) + 1) % DEPTH);
        cnt_q    <= cnt_q + 1'b1;
      end
      occ_q    <= occ_d;
      state_q  <= state_d;
      sticky_q <= sticky_d;
    end
  end

  assign sticky_flag = sticky_q;
  assign result_cnt  = cnt_q;

`ifdef ALU_RESULT_PARITY_EN
  logic [7:0] perr_q;

  // Flag bit 7 is expected to carry the odd-parity bit of acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_q <= '0;
    else if (push && (in_flag[7] != ~^in_acc) && (perr_q != 8'hFF)) perr_q <= perr_q + 1'b1;
  end

  assign out_par     = (^out_data) ^ out_hi;
  assign par_err_cnt = perr_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random traffic,
// compared against a queue-based model of the result stream.
module tb_alu_result_stage;

  localparam int DEPTH = 2;
  localparam logic [3:0] MUL = 4'b1110;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, sticky_clr = 1'b0;
  logic        in_ready, out_valid, out_hi, out_last;
  logic [3:0]  in_sel = '0;
  logic [31:0] in_acc = '0, in_mulh = '0, out_data;
  logic [7:0]  in_flag = '0, out_flag, sticky_flag;
  logic [15:0] result_cnt;
`ifdef ALU_RESULT_PARITY_EN
  logic        out_par;
  logic [7:0]  par_err_cnt;
`endif

  alu_result_stage #(.WIDTH(32), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_acc(in_acc),
    .in_mulh(in_mulh), .in_flag(in_flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flag(out_flag), .out_hi(out_hi), .out_last(out_last),
    .sticky_flag(sticky_flag), .sticky_clr(sticky_clr),
`ifdef ALU_RESULT_PARITY_EN
    .out_par(out_par), .par_err_cnt(par_err_cnt),
`endif
    .result_cnt(result_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] acc;
    logic [31:0] mulh;
    logic [7:0]  flag;
  } ent_t;

  ent_t        q[$];
  logic [31:0] popped[$];
  bit          m_hi;
  logic [15:0] m_cnt;
  logic [7:0]  m_sticky;
  int          m_perr;
  int          n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_hi = 1'b0;
    m_cnt = '0;
    m_sticky = '0;
    m_perr = 0;
  endtask

  task automatic compare_outputs();
    check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_data", 64'(out_data), 64'(m_hi ? q[0].mulh : q[0].acc));
      check("out_flag", 64'(out_flag), 64'(q[0].flag));
      check("out_hi", 64'(out_hi), 64'(m_hi));
      check("out_last", 64'(out_last), 64'(m_hi || q[0].sel != MUL));
`ifdef ALU_RESULT_PARITY_EN
      check("out_par", 64'(out_par), 64'((^(m_hi ? q[0].mulh : q[0].acc)) ^ m_hi));
`endif
    end
    check("sticky_flag", 64'(sticky_flag), 64'(m_sticky));
    check("result_cnt", 64'(result_cnt), 64'(m_cnt));
`ifdef ALU_RESULT_PARITY_EN
    check("par_err_cnt", 64'(par_err_cnt), 64'(m_perr));
`endif
  endtask

  // One clock cycle: optionally compare, advance the model from the driven inputs, then
  // return at the next falling edge where the caller may change inputs.
  task automatic tick(input bit do_check);
    bit ready_m, push_m, beat_m;
    if (do_check) compare_outputs();
    ready_m  = q.size() < DEPTH;
    push_m   = in_valid && ready_m;
    beat_m   = (q.size() != 0) && out_ready;
    m_sticky = (sticky_clr ? 8'h00 : m_sticky) | (push_m ? in_flag : 8'h00);
    if (beat_m) begin
      if (q[0].sel == MUL && !m_hi) m_hi = 1'b1;
      else begin
        popped.push_back(q[0].acc);
        void'(q.pop_front());
        m_hi  = 1'b0;
        m_cnt = m_cnt + 16'd1;
      end
    end
    if (push_m) begin
      q.push_back('{in_sel, in_acc, in_mulh, in_flag});
      if (in_flag[7] != ~^in_acc && m_perr < 255) m_perr++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] m, input logic [7:0] f);
    in_valid = v; in_sel = s; in_acc = a; in_mulh = m; in_flag = f;
  endtask

  task automatic drain();
    int guard = 0;
    set_in(1'b0, 4'h0, '0, '0, '0);
    out_ready = 1'b1;
    while (q.size() != 0 && guard < 20) begin tick(1'b1); guard++; end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic push_until_taken(input logic [3:0] s, input logic [31:0] a,
                                  input logic [31:0] m, input logic [7:0] f);
    bit taken;
    int guard = 0;
    set_in(1'b1, s, a, m, f);
    do begin
      taken = q.size() < DEPTH;
      tick(1'b1);
      guard++;
    end while (!taken && guard < 20);
    check("push_taken", 64'(taken), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 4'h0, '0, '0, '0);
    out_ready = 1'b0; sticky_clr = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    // Reset state, checked while reset is held.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_flag_hi_last", 64'({out_flag, out_hi, out_last}), 64'd0);
    check("rst_sticky_cnt", 64'({sticky_flag, result_cnt}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Single add.
    out_ready = 1'b1;
    set_in(1'b1, 4'b1001, 32'h5, 32'h0, 8'h40);
    tick(1'b1);
    set_in(1'b0, 4'h0, '0, '0, '0);
    check("add_data", 64'(out_data), 64'd5);
    check("add_last", 64'({out_valid, out_hi, out_last}), 64'b101);
    tick(1'b1);
    check("add_cnt", 64'(result_cnt), 64'd1);
    check("add_sticky", 64'(sticky_flag), 64'h40);

    // Multiply: low beat then high beat, one count.
    set_in(1'b1, MUL, 32'h89AB_CDEF, 32'h0123_4567, 8'h01);
    tick(1'b1);
    in_valid = 1'b0;
    check("mul_lo", 64'({out_data, out_hi, out_last}), {30'd0, 32'h89AB_CDEF, 2'b00});
    tick(1'b1);
    check("mul_hi", 64'({out_data, out_hi, out_last}), {30'd0, 32'h0123_4567, 2'b11});
    tick(1'b1);
    check("mul_cnt", 64'(result_cnt), 64'd2);

    // Backpressure: three pushes offered, two accepted, head held for 10 cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 4'b0001, 32'hA0 + 32'(i), 32'h0, 8'h04);
      tick(1'b1);
    end
    in_valid = 1'b0;
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1);
      check("bp_hold", 64'(out_data), 64'hA0);
    end
    popped.delete();
    drain();
    check("bp_order_len", 64'(popped.size()), 64'd2);
    if (popped.size() == 2) check("bp_order", 64'({popped[0], popped[1]}), {32'hA0, 32'hA1});

    // Push/pop at full: the sequence 1,2,3,4 must come out intact.
    popped.delete();
    out_ready = 1'b0;
    push_until_taken(4'b0010, 32'd1, 32'h0, 8'h00);
    push_until_taken(4'b0010, 32'd2, 32'h0, 8'h00);
    out_ready = 1'b1;
    push_until_taken(4'b0010, 32'd3, 32'h0, 8'h00);
    push_until_taken(4'b0010, 32'd4, 32'h0, 8'h00);
    drain();
    check("seq_len", 64'(popped.size()), 64'd4);
    for (int i = 0; i < popped.size() && i < 4; i++) check("seq_item", 64'(popped[i]), 64'(i + 1));

    // Reset while the high beat of a multiply is being presented.
    out_ready = 1'b1;
    set_in(1'b1, MUL, 32'h1111_2222, 32'h3333_4444, 8'h10);
    tick(1'b1);
    in_valid = 1'b0;
    tick(1'b1);
    check("mid_mul_hi", 64'(out_hi), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outs", 64'({out_valid, out_hi, out_last, out_flag}), 64'd0);
    check("async_rst_data", 64'(out_data), 64'd0);
    check("async_rst_cnt", 64'({sticky_flag, result_cnt}), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("post_rst_cnt", 64'(result_cnt), 64'd0);
    tick(1'b1);

    // Counter wrap: 65536 single-beat pops from zero.
    begin
      int guard = 0;
      out_ready = 1'b1;
      set_in(1'b1, 4'b0011, 32'h7, 32'h0, 8'h01);
      while (m_cnt != 16'hFFFF && guard < 70000) begin tick(1'b0); guard++; end
      check("wrap_preload", 64'(result_cnt), 64'hFFFF);
      in_valid = 1'b0;
      tick(1'b1);
      check("wrap_zero", 64'(result_cnt), 64'd0);
    end

    // Sticky clear together with a push.
    check("sticky_before_clr", 64'(sticky_flag), 64'h01);
    sticky_clr = 1'b1;
    set_in(1'b1, 4'b0100, 32'h9, 32'h0, 8'h02);
    tick(1'b1);
    sticky_clr = 1'b0;
    in_valid = 1'b0;
    check("sticky_clr_push", 64'(sticky_flag), 64'h02);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? MUL : 4'($urandom),
             $urandom, $urandom, 8'($urandom));
      out_ready  = $urandom_range(0, 3) != 0;
      sticky_clr = $urandom_range(0, 15) == 0;
      tick(1'b1);
    end
    sticky_clr = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
